// File: rtl/mips_divider_pkg.sv
// Shared constants and FSM encoding for the iterative DIV/DIVU unit.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/mips_divider_if.sv
// Operand and result handshakes between the EXE stage and the divider.
interface mips_divider_if
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);

    logic             div_valid;
    logic             div_ready;
    logic             div_signed;
    logic [WIDTH-1:0] div_src1;
    logic [WIDTH-1:0] div_src2;
    logic             div_flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;

    modport master (
        output div_valid, div_signed, div_src1, div_src2, div_flush, out_ready,
        input  div_ready, out_valid, div_q, div_r
    );

    modport slave (
        input  div_valid, div_signed, div_src1, div_src2, div_flush, out_ready,
        output div_ready, out_valid, div_q, div_r
    );

endinterface

// File: rtl/mips_divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // No borrow means the true difference is below the divisor, so the low WIDTH bits are exact.
    always_comb begin
        shifted = {rem_i, dvd_bit_i};
        q_bit_o = (shifted >= {1'b0, dvs_i});
        diff    = shifted[WIDTH-1:0] - dvs_i;
        rem_o   = q_bit_o ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/mips_divider.sv
// Iterative 32-bit DIV/DIVU unit: one restoring step per cycle, sign fix-up on completion.
module mips_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic          clk,
    input  logic          resetn,
    mips_divider_if.slave dif
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] src1_q, src1_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] res_q_q, res_q_d;
    logic [WIDTH-1:0] res_r_q, res_r_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] quo_next;
    logic             src1_neg;
    logic             src2_neg;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (rem_q),
        .dvd_bit_i(dq_q[WIDTH-1]),
        .dvs_i    (dvs_q),
        .rem_o    (step_rem),
        .q_bit_o  (step_qbit)
    );

    // Dividend bits leave at the top while quotient bits enter at the bottom of one register.
    assign quo_next = {dq_q[WIDTH-2:0], step_qbit};
    assign src1_neg = dif.div_signed & dif.div_src1[WIDTH-1];
    assign src2_neg = dif.div_signed & dif.div_src2[WIDTH-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        src1_d  = src1_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        res_q_d = res_q_q;
        res_r_d = res_r_q;

        case (state_q)
            DIV_IDLE: begin
                if (dif.div_valid) begin
                    state_d = DIV_CALC;
                    cnt_d   = '0;
                    dq_d    = src1_neg ? -dif.div_src1 : dif.div_src1;
                    dvs_d   = src2_neg ? -dif.div_src2 : dif.div_src2;
                    rem_d   = '0;
                    src1_d  = dif.div_src1;
                    q_neg_d = src1_neg ^ src2_neg;
                    r_neg_d = src1_neg;
                end
            end
            DIV_CALC: begin
                rem_d = step_rem;
                dq_d  = quo_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DIV_DONE;
                    if (dvs_q == '0) begin
                        res_q_d = '1;
                        res_r_d = src1_q;
                    end else begin
                        res_q_d = q_neg_q ? -quo_next : quo_next;
                        res_r_d = r_neg_q ? -step_rem : step_rem;
                    end
                end
            end
            DIV_DONE: begin
                if (dif.out_ready) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase

        // Flush outranks accept and result hand-off in every state.
        if (dif.div_flush) begin
            state_d = DIV_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            src1_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            res_q_q <= '0;
            res_r_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            src1_q  <= src1_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            res_q_q <= res_q_d;
            res_r_q <= res_r_d;
        end
    end

    assign dif.div_ready = (state_q == DIV_IDLE);
    assign dif.out_valid = (state_q == DIV_DONE);
    assign dif.div_q     = res_q_q;
    assign dif.div_r     = res_r_q;

endmodule
